// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the fetch PC, drives the I-cache read and loads IF/ID.
// Data_out updates one cycle after icache_resp; MA_stall freezes IF/ID and parks a response in a one-entry buffer.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  input  logic        icache_resp,
  input  logic        MA_stall,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic        IF_stall,
  output logic [31:0] PC_out,
  output logic [31:0] data_out
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] data_out_q, data_out_d;

  logic        take;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] req_next;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    hold_buf_d  = hold_buf_q;
    hold_pc_d   = hold_pc_q;
    pc_out_d    = pc_out_q;
    data_out_d  = data_out_q;
    icache_read = 1'b0;
    take        = 1'b0;
    target      = {br_target[31:2], 2'b00};
    redirect    = br_en & ~MA_stall;
    req_next    = req_addr_q + 32'd4;

    case (state_q)
      S_FETCH: begin
        icache_read = 1'b1;
        if (icache_resp) begin
          if (redirect) begin
            req_addr_d = target;
            fetch_pc_d = target;
            data_out_d = NOP_INSN;
          end else if (MA_stall) begin
            hold_buf_d = icache_rdata;
            hold_pc_d  = req_addr_q;
            fetch_pc_d = req_next;
            state_d    = S_HOLD;
          end else begin
            take       = 1'b1;
            pc_out_d   = req_addr_q;
            data_out_d = icache_rdata;
            fetch_pc_d = req_next;
            req_addr_d = req_next;
          end
        end else if (redirect) begin
          // The read in flight is stale; let it complete before re-requesting.
          fetch_pc_d = target;
          data_out_d = NOP_INSN;
          state_d    = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (!MA_stall) begin
          state_d = S_FETCH;
          if (br_en) begin
            data_out_d = NOP_INSN;
            req_addr_d = target;
            fetch_pc_d = target;
          end else begin
            take       = 1'b1;
            pc_out_d   = hold_pc_q;
            data_out_d = hold_buf_q;
            req_addr_d = fetch_pc_q;
          end
        end
      end
      S_DRAIN: begin
        icache_read = 1'b1;
        if (redirect) fetch_pc_d = target;
        if (icache_resp) begin
          req_addr_d = redirect ? target : fetch_pc_q;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      icache_read = 1'b0;
      take        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_buf_q <= NOP_INSN;
      hold_pc_q  <= 32'd0;
      pc_out_q   <= 32'd0;
      data_out_q <= NOP_INSN;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      hold_buf_q <= hold_buf_d;
      hold_pc_q  <= hold_pc_d;
      pc_out_q   <= pc_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign icache_address = req_addr_q;
  assign IF_stall       = ~take;
  assign PC_out         = pc_out_q;
  assign data_out       = data_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle table, async reset check, then random traffic vs a model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0060;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_read;
  logic [31:0] icache_address;
  logic [31:0] icache_rdata = 32'd0;
  logic        icache_resp = 1'b0;
  logic        MA_stall = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        IF_stall;
  logic [31:0] PC_out;
  logic [31:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .MA_stall(MA_stall), .br_en(br_en), .br_target(br_target),
    .IF_stall(IF_stall), .PC_out(PC_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, resp, ma, br;
    logic [31:0] rdata, target;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_stall;
    logic [31:0] e_pc, e_data;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic r, input logic rs, input logic [31:0] rd,
                              input logic ma, input logic br, input logic [31:0] tg,
                              input logic er, input logic [31:0] ea, input logic es,
                              input logic [31:0] ep, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.resp = rs; v.rdata = rd; v.ma = ma; v.br = br; v.target = tg;
    v.e_read = er; v.e_addr = ea; v.e_stall = es; v.e_pc = ep; v.e_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic er, input logic es, input logic [31:0] ea,
                       input logic [31:0] ep, input logic [31:0] ed);
    n_tests++;
    if (icache_read !== er || IF_stall !== es || icache_address !== ea ||
        PC_out !== ep || data_out !== ed) begin
      n_fail++;
      $display("FAIL %s[%0d]: got read=%b stall=%b addr=%h pc=%h data=%h, expected read=%b stall=%b addr=%h pc=%h data=%h",
               name, idx, icache_read, IF_stall, icache_address, PC_out, data_out,
               er, es, ea, ep, ed);
    end
  endtask

  // Reference model: transaction view of the fetch stage.
  logic [31:0] m_bus, m_next, m_buf_pc, m_buf_ins, m_pc, m_ins;
  logic        m_have_buf, m_stale;

  task automatic model_reset();
    m_bus = RST_PC; m_next = RST_PC;
    m_have_buf = 1'b0; m_stale = 1'b0;
    m_buf_pc = 32'd0; m_buf_ins = NOP;
    m_pc = 32'd0; m_ins = NOP;
  endtask

  task automatic model_step(input logic resp, input logic [31:0] rdata, input logic ma,
                            input logic br, input logic [31:0] tgt_raw);
    logic        redir;
    logic [31:0] tgt;
    redir = br && !ma;
    tgt   = tgt_raw & 32'hFFFF_FFFC;
    if (m_have_buf) begin
      if (!ma) begin
        m_have_buf = 1'b0;
        if (br) begin
          m_ins = NOP; m_bus = tgt; m_next = tgt;
        end else begin
          m_pc = m_buf_pc; m_ins = m_buf_ins; m_bus = m_next;
        end
      end
    end else if (m_stale) begin
      if (redir) m_next = tgt;
      if (resp) begin
        m_stale = 1'b0; m_bus = m_next;
      end
    end else if (resp) begin
      if (redir) begin
        m_ins = NOP; m_bus = tgt; m_next = tgt;
      end else if (ma) begin
        m_have_buf = 1'b1; m_buf_pc = m_bus; m_buf_ins = rdata; m_next = m_bus + 32'd4;
      end else begin
        m_pc = m_bus; m_ins = rdata; m_bus = m_bus + 32'd4; m_next = m_bus;
      end
    end else if (redir) begin
      m_ins = NOP; m_next = tgt; m_stale = 1'b1;
    end
  endtask

  initial begin
    // Columns: rst resp rdata ma br target | read addr stall pc data (values just before the edge)
    vecs[0]  = mk(1,0,32'h0,0,0,32'h0,            0,32'h60,1,32'h0,32'h13);
    vecs[1]  = mk(0,1,32'h60,0,0,32'h0,           1,32'h60,0,32'h0,32'h13);
    vecs[2]  = mk(0,1,32'h64,0,0,32'h0,           1,32'h64,0,32'h60,32'h60);
    vecs[3]  = mk(0,0,32'h0,0,0,32'h0,            1,32'h68,1,32'h64,32'h64);
    vecs[4]  = mk(0,0,32'h0,0,0,32'h0,            1,32'h68,1,32'h64,32'h64);
    vecs[5]  = mk(0,1,32'h68,0,0,32'h0,           1,32'h68,0,32'h64,32'h64);
    vecs[6]  = mk(0,1,32'h6C,1,0,32'h0,           1,32'h6C,1,32'h68,32'h68);
    vecs[7]  = mk(0,0,32'h0,1,0,32'h0,            0,32'h6C,1,32'h68,32'h68);
    vecs[8]  = mk(0,1,32'hBAD,1,0,32'h0,          0,32'h6C,1,32'h68,32'h68);
    vecs[9]  = mk(0,0,32'h0,0,0,32'h0,            0,32'h6C,0,32'h68,32'h68);
    vecs[10] = mk(0,0,32'h0,0,1,32'h1002,         1,32'h70,1,32'h6C,32'h6C);
    vecs[11] = mk(0,0,32'h0,0,0,32'h0,            1,32'h70,1,32'h6C,32'h13);
    vecs[12] = mk(0,1,32'hDEAD,0,0,32'h0,         1,32'h70,1,32'h6C,32'h13);
    vecs[13] = mk(0,1,32'h1000,0,1,32'h2000,      1,32'h1000,1,32'h6C,32'h13);
    vecs[14] = mk(0,1,32'h2000,0,0,32'h0,         1,32'h2000,0,32'h6C,32'h13);
    vecs[15] = mk(0,0,32'h0,1,1,32'h3000,         1,32'h2004,1,32'h2000,32'h2000);
    vecs[16] = mk(0,1,32'h2004,0,0,32'h0,         1,32'h2004,0,32'h2000,32'h2000);
    vecs[17] = mk(0,1,32'h5555,0,1,32'hFFFF_FFFF, 1,32'h2008,1,32'h2004,32'h2004);
    vecs[18] = mk(0,1,32'hAAAA,0,0,32'h0,         1,32'hFFFF_FFFC,0,32'h2004,32'h13);
    vecs[19] = mk(0,0,32'h0,0,0,32'h0,            1,32'h0,1,32'hFFFF_FFFC,32'hAAAA);
    vecs[20] = mk(1,0,32'h0,0,0,32'h0,            0,32'h60,1,32'h0,32'h13);
    vecs[21] = mk(0,0,32'h0,0,0,32'h0,            1,32'h60,1,32'h0,32'h13);
    vecs[22] = mk(0,1,32'h111,1,0,32'h0,          1,32'h60,1,32'h0,32'h13);
    vecs[23] = mk(0,0,32'h0,1,0,32'h0,            0,32'h60,1,32'h0,32'h13);
    vecs[24] = mk(1,0,32'h0,1,0,32'h0,            0,32'h60,1,32'h0,32'h13);
    vecs[25] = mk(0,1,32'h60,0,0,32'h0,           1,32'h60,0,32'h0,32'h13);
    vecs[26] = mk(0,0,32'h0,0,0,32'h0,            1,32'h64,1,32'h60,32'h60);
    vecs[27] = mk(0,0,32'h0,0,1,32'h500,          1,32'h64,1,32'h60,32'h60);
    vecs[28] = mk(0,0,32'h0,0,1,32'h600,          1,32'h64,1,32'h60,32'h13);
    vecs[29] = mk(0,1,32'hEEEE,1,0,32'h0,         1,32'h64,1,32'h60,32'h13);
    vecs[30] = mk(0,1,32'h77,0,0,32'h0,           1,32'h600,0,32'h60,32'h13);
    vecs[31] = mk(0,0,32'h0,0,0,32'h0,            1,32'h604,1,32'h600,32'h77);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; icache_resp = vecs[i].resp; icache_rdata = vecs[i].rdata;
      MA_stall = vecs[i].ma; br_en = vecs[i].br; br_target = vecs[i].target;
      #1;
      check("table", i, vecs[i].e_read, vecs[i].e_stall, vecs[i].e_addr,
            vecs[i].e_pc, vecs[i].e_data);
    end

    // Reset asserted between edges must take effect without a clock.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", 0, 1'b0, 1'b1, RST_PC, 32'd0, NOP);

    model_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(99) < 2);
      icache_resp  = ($urandom_range(1) == 1);
      icache_rdata = $urandom;
      MA_stall     = ($urandom_range(3) == 0);
      br_en        = ($urandom_range(9) == 0);
      br_target    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                              : $urandom;
      if (rst) model_reset();
      #1;
      check("rand", c, !rst && !m_have_buf,
            !(!rst && !MA_stall && !br_en && (m_have_buf || (icache_resp && !m_stale))),
            m_bus, m_pc, m_ins);
      if (!rst) model_step(icache_resp, icache_rdata, MA_stall, br_en, br_target);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
